// File: rtl/seven_seg_pkg.sv
// Shared segment encodings and the hex-to-segment lookup for the seven-segment display path.
// Segment bit order is {a,b,c,d,e,f,g}, bit 6 = a; a 1 lights the segment.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h1F;
  localparam logic [6:0] SEG_C     = 7'h4E;
  localparam logic [6:0] SEG_D     = 7'h3D;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_F     = 7'h47;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    unique case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment pattern.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed hex display driver: prescaled digit scan, frame-synchronous double buffer,
// leading-zero blanking and registered pin outputs with selectable polarity.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned PRESCALE   = 1000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PcntMax = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]     IdxMax  = IW'(DIGITS - 1);
  localparam logic [6:0]        SegOff  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DpOff   = ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AnOff   = {DIGITS{ACTIVE_LOW}};

  // Scan state
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tick, boundary;

  // Display buffers
  logic [4*DIGITS-1:0] act_val_q, act_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic                transfer;

  // Digit decode
  logic [DIGITS-1:0] blank_mask;
  logic              zero_upper;
  logic [3:0]        cur_nib;
  logic [6:0]        dec_seg;

  // Output register
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q, frame_done_d;

  // ---------------------------------------------------------------------------------------------
  // Prescaler and digit index
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    tick     = enable && (pcnt_q == PcntMax);
    boundary = tick && (idx_q == IdxMax);
  end

  always_comb begin
    pcnt_d = pcnt_q;
    idx_d  = idx_q;
    if (tick) begin
      pcnt_d = '0;
      idx_d  = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end else if (enable) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      idx_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Double buffer: active only changes at a frame boundary or while the display is dark
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    transfer     = (boundary || !enable) && (pend_valid_q || load);
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (transfer) begin
      // A same-cycle load bypasses pending so the newest value is never lost
      act_val_d    = load ? value : pend_val_q;
      act_dp_d     = load ? dp_in : pend_dp_q;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Leading-zero mask and digit decode
  // ---------------------------------------------------------------------------------------------
  // Walk from the most significant digit down; digit 0 always stays lit.
  always_comb begin
    zero_upper = 1'b1;
    blank_mask = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_upper = zero_upper && (act_val_q[4*i +: 4] == 4'h0);
      if (i != 0) begin
        blank_mask[i] = lz_en && zero_upper;
      end
    end
  end

  always_comb begin
    cur_nib = act_val_q[4*idx_q +: 4];
  end

  hex_to_seg7 u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // ---------------------------------------------------------------------------------------------
  // Output register with polarity applied at its input
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    seg_d        = SEG_BLANK;
    dp_d         = 1'b0;
    an_d         = '0;
    frame_done_d = boundary;
    if (enable) begin
      an_d[idx_q] = 1'b1;
      seg_d       = blank_mask[idx_q] ? SEG_BLANK : dec_seg;
      dp_d        = act_dp_q[idx_q];
    end
    if (ACTIVE_LOW) begin
      seg_d = ~seg_d;
      dp_d  = ~dp_d;
      an_d  = ~an_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q        <= SegOff;
      dp_q         <= DpOff;
      an_q         <= AnOff;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    seg        = seg_q;
    dp         = dp_q;
    an         = an_q;
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: a frame-position model checked every cycle against an
// active-high and an active-low instance, plus directed literal checks of each scenario.
module tb_seven_seg_scan_driver;

  localparam int DIG   = 4;
  localparam int PRE   = 4;
  localparam int FRAME = DIG * PRE;

  localparam logic [27:0] S1234 = {7'h30, 7'h6D, 7'h79, 7'h33};
  localparam logic [27:0] SABCD = {7'h77, 7'h1F, 7'h4E, 7'h3D};
  localparam logic [27:0] S0050 = {7'h00, 7'h00, 7'h5B, 7'h7E};
  localparam logic [27:0] S0000 = {7'h00, 7'h00, 7'h00, 7'h7E};
  localparam logic [27:0] S5555 = {7'h5B, 7'h5B, 7'h5B, 7'h5B};

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        enable = 1'b0;
  logic        load   = 1'b0;
  logic        lz_en  = 1'b0;
  logic [15:0] value  = '0;
  logic [3:0]  dp_in  = '0;

  logic [6:0] seg_h, seg_l;
  logic       dp_h, dp_l, fd_h, fd_l;
  logic [3:0] an_h, an_l;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.DIGITS(DIG), .PRESCALE(PRE), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .seg        (seg_h),
    .dp         (dp_h),
    .an         (an_h),
    .frame_done (fd_h)
  );

  seven_seg_scan_driver #(.DIGITS(DIG), .PRESCALE(PRE), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .seg        (seg_l),
    .dp         (dp_l),
    .an         (an_l),
    .frame_done (fd_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------------
  // Model: position within the frame in cycles, plus active/pending display contents
  // ---------------------------------------------------------------------------------------------
  logic [6:0]  seg_tab [16];
  initial seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int          pos;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_pv, m_ok, wrap;
  int          d;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;
  logic [3:0]  e_an;

  always @(posedge clk) begin
    if (!rst_n) begin
      pos = 0; m_act = '0; m_pend = '0; m_act_dp = '0; m_pend_dp = '0; m_pv = 0;
      e_seg = '0; e_dp = 1'b0; e_an = '0; e_fd = 1'b0;
      m_ok = 1;
    end else begin
      d    = pos / PRE;
      wrap = enable && (pos == FRAME - 1);
      if (enable) begin
        e_an  = 4'(1 << d);
        e_seg = (lz_en && d != 0 && (m_act >> (4 * d)) == 16'h0) ? 7'h00 : seg_tab[m_act[4*d +: 4]];
        e_dp  = m_act_dp[d];
      end else begin
        e_an = '0; e_seg = '0; e_dp = 1'b0;
      end
      e_fd = wrap;
      if ((wrap || !enable) && (m_pv || load)) begin
        m_act    = load ? value : m_pend;
        m_act_dp = load ? dp_in : m_pend_dp;
        m_pv     = 0;
      end else if (load) begin
        m_pend = value; m_pend_dp = dp_in; m_pv = 1;
      end
      if (enable) pos = (pos + 1) % FRAME;
    end
  end

  logic [6:0] l_seg;
  logic       l_dp;
  logic [3:0] l_an;

  always @(posedge clk) begin
    #1;
    if (m_ok) begin
      chk("seg", 32'(seg_h), 32'(e_seg));
      chk("dp", 32'(dp_h), 32'(e_dp));
      chk("an", 32'(an_h), 32'(e_an));
      chk("frame_done", 32'(fd_h), 32'(e_fd));
      l_seg = ~e_seg;
      l_dp  = ~e_dp;
      l_an  = ~e_an;
      chk("seg_lo", 32'(seg_l), 32'(l_seg));
      chk("dp_lo", 32'(dp_l), 32'(l_dp));
      chk("an_lo", 32'(an_l), 32'(l_an));
      chk("frame_done_lo", 32'(fd_l), 32'(e_fd));
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Directed literal checks; slot k (1..16) is the k-th cycle of a frame on the outputs
  // ---------------------------------------------------------------------------------------------
  task automatic slots(input logic [27:0] segs, input int lo, input int hi);
    logic [3:0] x_an;
    logic [6:0] x_seg;
    int         dg;
    for (int k = lo; k <= hi; k++) begin
      @(negedge clk);
      dg    = (k - 1) / PRE;
      x_an  = 4'(1 << dg);
      x_seg = segs[7*dg +: 7];
      chk("lit_an", 32'(an_h), 32'(x_an));
      chk("lit_seg", 32'(seg_h), 32'(x_seg));
      chk("lit_frame_done", 32'(fd_h), (k == FRAME) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic load_during_frame(input logic [27:0] cur, input logic [15:0] v);
    load  = 1'b1;
    value = v;
    slots(cur, 1, 1);
    load  = 1'b0;
    slots(cur, 2, FRAME);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    // Reset state on both polarities
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg_h), 32'h00);
    chk("rst_an", 32'(an_h), 32'h0);
    chk("rst_frame_done", 32'(fd_h), 32'h0);
    chk("rst_seg_lo", 32'(seg_l), 32'h7F);
    chk("rst_dp_lo", 32'(dp_l), 32'h1);
    chk("rst_an_lo", 32'(an_l), 32'hF);

    // Load while dark goes straight to active, then scan two frames
    rst_n = 1'b1;
    load  = 1'b1;
    value = 16'h1234;
    @(negedge clk);
    load   = 1'b0;
    enable = 1'b1;
    slots(S1234, 1, FRAME);
    slots(S1234, 1, FRAME);

    // Mid-frame load during digit 2 must not tear the current frame
    slots(S1234, 1, 9);
    load  = 1'b1;
    value = 16'hABCD;
    slots(S1234, 10, 10);
    load  = 1'b0;
    chk("pend_valid_set", 32'(dut_hi.pend_valid_q), 32'h1);
    slots(S1234, 11, FRAME);
    chk("pend_valid_clr", 32'(dut_hi.pend_valid_q), 32'h0);
    slots(SABCD, 1, FRAME);

    // Leading-zero suppression
    lz_en = 1'b1;
    load_during_frame(SABCD, 16'h0050);
    load_during_frame(S0050, 16'h0000);
    load_during_frame(S0000, 16'h1234);

    // Enable drop at pcnt=1 of digit 1
    slots(S1234, 1, 5);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("dark_an", 32'(an_h), 32'h0);
      chk("dark_seg", 32'(seg_h), 32'h00);
      chk("dark_frame_done", 32'(fd_h), 32'h0);
    end
    enable = 1'b1;
    slots(S1234, 6, FRAME);
    slots(S1234, 1, FRAME);

    // Earlier pending load overridden by a load on the wrapping tick
    slots(S1234, 1, 1);
    load  = 1'b1;
    value = 16'h9999;
    slots(S1234, 2, 2);
    load  = 1'b0;
    slots(S1234, 3, FRAME - 1);
    load  = 1'b1;
    value = 16'h5555;
    slots(S1234, FRAME, FRAME);
    load  = 1'b0;
    chk("collide_pend_valid", 32'(dut_hi.pend_valid_q), 32'h0);
    slots(S5555, 1, FRAME);
    slots(S5555, 1, FRAME);

    // Polarity: digit 0 = 8 with its decimal point
    enable = 1'b0;
    load   = 1'b1;
    value  = 16'h0008;
    dp_in  = 4'b0001;
    @(negedge clk);
    load   = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("pol_seg_lo", 32'(seg_l), 32'h00);
    chk("pol_dp_lo", 32'(dp_l), 32'h0);
    chk("pol_an_lo", 32'(an_l), 32'hE);
    chk("pol_seg_hi", 32'(seg_h), 32'h7F);
    chk("pol_dp_hi", 32'(dp_h), 32'h1);

    // Reset mid-frame aborts it; scanning restarts at digit 0
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_frame_done", 32'(fd_h), 32'h0);
    chk("abort_an", 32'(an_h), 32'h0);
    rst_n = 1'b1;
    enable = 1'b0;
    load   = 1'b1;
    value  = 16'h1234;
    dp_in  = 4'b0000;
    lz_en  = 1'b0;
    @(negedge clk);
    load   = 1'b0;
    enable = 1'b1;
    slots(S1234, 1, FRAME);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
